// File: rtl/br_pkg.sv
// Shared definitions for the branch resolve unit: ex_op encodings, 2-bit
// counter states and the saturating counter update.
package br_pkg;

    localparam logic [2:0] OP_EQ     = 3'b000;
    localparam logic [2:0] OP_NE     = 3'b001;
    localparam logic [2:0] OP_NEVER  = 3'b010;
    localparam logic [2:0] OP_ALWAYS = 3'b011;
    localparam logic [2:0] OP_LT     = 3'b100;
    localparam logic [2:0] OP_GE     = 3'b101;
    localparam logic [2:0] OP_LTU    = 3'b110;
    localparam logic [2:0] OP_GEU    = 3'b111;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt_t;

    function automatic logic [1:0] sat_update(input logic [1:0] cnt, input logic taken);
        logic [1:0] result;
        if (taken) begin
            result = (cnt == 2'(ST)) ? 2'(ST) : cnt + 2'd1;
        end else begin
            result = (cnt == 2'(SNT)) ? 2'(SNT) : cnt - 2'd1;
        end
        return result;
    endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: (a, b, op) -> taken.
module branch_cmp
    import br_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    input  logic [2:0]      i_op,
    output logic            o_taken
);

    always_comb begin
        o_taken = 1'b0;
        case (i_op)
            OP_EQ:     o_taken = (i_a == i_b);
            OP_NE:     o_taken = (i_a != i_b);
            OP_NEVER:  o_taken = 1'b0;
            OP_ALWAYS: o_taken = 1'b1;
            OP_LT:     o_taken = ($signed(i_a) <  $signed(i_b));
            OP_GE:     o_taken = ($signed(i_a) >= $signed(i_b));
            OP_LTU:    o_taken = (i_a <  i_b);
            OP_GEU:    o_taken = (i_a >= i_b);
            default:   o_taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Resolves EX-stage branches into a registered result (direction, mispredict,
// redirect PC) and trains a bimodal 2-bit BHT that fetch reads combinationally.
module branch_resolve_unit
    import br_pkg::*;
#(
    parameter int         XLEN      = 32,
    parameter int         BHT_DEPTH = 64,
    parameter int         PC_LSB    = 2,
    parameter logic [1:0] CNT_INIT  = 2'b01
) (
    input  logic            i_clk,
    input  logic            i_reset,
    input  logic [XLEN-1:0] i_lookup_pc,
    output logic            o_lookup_taken,
    input  logic            i_ex_valid,
    input  logic [XLEN-1:0] i_ex_a,
    input  logic [XLEN-1:0] i_ex_b,
    input  logic [2:0]      i_ex_op,
    input  logic [XLEN-1:0] i_ex_pc,
    input  logic [XLEN-1:0] i_ex_target,
    input  logic            i_ex_pred_taken,
    input  logic            i_stall,
    input  logic            i_flush,
    output logic            o_res_valid,
    output logic            o_res_taken,
    output logic            o_res_mispredict,
    output logic [XLEN-1:0] o_res_redirect_pc,
    output logic [XLEN-1:0] o_res_pc
);

    localparam int IDX_W = (BHT_DEPTH > 1) ? $clog2(BHT_DEPTH) : 1;

    logic [1:0]      r_bht [BHT_DEPTH];
    logic            r_res_valid;
    logic            r_res_taken;
    logic            r_res_mispredict;
    logic [XLEN-1:0] r_res_redirect_pc;
    logic [XLEN-1:0] r_res_pc;

    logic             w_taken;
    logic [IDX_W-1:0] w_lookup_idx;
    logic [IDX_W-1:0] w_ex_idx;
    logic [XLEN-1:0]  w_redirect_pc;
    logic             w_capture;
    logic             w_train;
    logic             w_unused;

    branch_cmp #(
        .XLEN (XLEN)
    ) u_cmp (
        .i_a     (i_ex_a),
        .i_b     (i_ex_b),
        .i_op    (i_ex_op),
        .o_taken (w_taken)
    );

    // Upper PC bits deliberately alias into the same entry.
    assign w_lookup_idx   = i_lookup_pc[PC_LSB +: IDX_W];
    assign w_ex_idx       = i_ex_pc[PC_LSB +: IDX_W];
    assign o_lookup_taken = r_bht[w_lookup_idx][1];
    assign w_unused       = ^i_lookup_pc;

    assign w_redirect_pc = w_taken ? i_ex_target : i_ex_pc + XLEN'(4);
    assign w_capture     = !i_flush && !i_stall;
    assign w_train       = w_capture && i_ex_valid && (i_ex_op[2:1] != 2'b01);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_res_valid       <= 1'b0;
            r_res_taken       <= 1'b0;
            r_res_mispredict  <= 1'b0;
            r_res_redirect_pc <= '0;
            r_res_pc          <= '0;
        end else if (i_flush) begin
            r_res_valid      <= 1'b0;
            r_res_mispredict <= 1'b0;
        end else if (!i_stall) begin
            r_res_valid       <= i_ex_valid;
            r_res_taken       <= w_taken;
            r_res_mispredict  <= i_ex_valid && (w_taken != i_ex_pred_taken);
            r_res_redirect_pc <= w_redirect_pc;
            r_res_pc          <= i_ex_pc;
        end
    end

    // Lookup reads the pre-update counter; the trained value appears next cycle.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < BHT_DEPTH; i++) begin
                r_bht[i] <= CNT_INIT;
            end
        end else if (w_train) begin
            r_bht[w_ex_idx] <= sat_update(r_bht[w_ex_idx], w_taken);
        end
    end

    assign o_res_valid       = r_res_valid;
    assign o_res_taken       = r_res_taken;
    assign o_res_mispredict  = r_res_mispredict;
    assign o_res_redirect_pc = r_res_redirect_pc;
    assign o_res_pc          = r_res_pc;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit.
module tb_branch_resolve_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] lookup_pc;
    logic        lookup_taken;
    logic        ex_valid;
    logic [31:0] ex_a, ex_b, ex_pc, ex_target;
    logic [2:0]  ex_op;
    logic        ex_pred_taken;
    logic        stall, flush;
    logic        res_valid, res_taken, res_mispredict;
    logic [31:0] res_redirect_pc, res_pc;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    branch_resolve_unit dut (
        .i_clk             (clk),
        .i_reset           (reset),
        .i_lookup_pc       (lookup_pc),
        .o_lookup_taken    (lookup_taken),
        .i_ex_valid        (ex_valid),
        .i_ex_a            (ex_a),
        .i_ex_b            (ex_b),
        .i_ex_op           (ex_op),
        .i_ex_pc           (ex_pc),
        .i_ex_target       (ex_target),
        .i_ex_pred_taken   (ex_pred_taken),
        .i_stall           (stall),
        .i_flush           (flush),
        .o_res_valid       (res_valid),
        .o_res_taken       (res_taken),
        .o_res_mispredict  (res_mispredict),
        .o_res_redirect_pc (res_redirect_pc),
        .o_res_pc          (res_pc)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc,
                         input logic [31:0] tgt, input logic pred);
        ex_valid = v; ex_op = op; ex_a = a; ex_b = b;
        ex_pc = pc; ex_target = tgt; ex_pred_taken = pred;
    endtask

    logic [2:0] sweep_op  [8] = '{3'b000, 3'b001, 3'b100, 3'b101, 3'b110, 3'b111, 3'b010, 3'b011};
    logic       sweep_exp [8] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic       train_exp [3] = '{1'b1, 1'b1, 1'b1};
    logic       untrain_exp [4] = '{1'b1, 1'b0, 1'b0, 1'b0};

    initial begin
        reset = 1'b1; stall = 1'b0; flush = 1'b0; lookup_pc = 32'h100;
        drive(1'b0, 3'b000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        step(); step();
        check("rst_valid", {31'd0, res_valid}, 32'd0);
        check("rst_taken", {31'd0, res_taken}, 32'd0);
        check("rst_misp", {31'd0, res_mispredict}, 32'd0);
        check("rst_redirect", res_redirect_pc, 32'd0);
        check("rst_pc", res_pc, 32'd0);
        check("rst_lookup", {31'd0, lookup_taken}, 32'd0);
        reset = 1'b0;

        // 1. ops sweep on pc 'h40 (its own BHT entry)
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, sweep_op[i], 32'hFFFF_FFFF, 32'h1, 32'h40, 32'h300, 1'b0);
            step();
            $display("sweep op=%b taken=%0d redirect=%h", sweep_op[i], res_taken, res_redirect_pc);
            check("sweep_taken", {31'd0, res_taken}, {31'd0, sweep_exp[i]});
            check("sweep_valid", {31'd0, res_valid}, 32'd1);
            check("sweep_redirect", res_redirect_pc, sweep_exp[i] ? 32'h300 : 32'h44);
        end

        // 2. training of 'h100 (starts weakly not-taken)
        check("train_init", {31'd0, lookup_taken}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h400, 1'b0);
            step();
            $display("train taken #%0d lookup=%0d", i, lookup_taken);
            check("train_up", {31'd0, lookup_taken}, {31'd0, train_exp[i]});
        end
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 3'b000, 32'h5, 32'h6, 32'h100, 32'h400, 1'b1);
            step();
            $display("train not-taken #%0d lookup=%0d", i, lookup_taken);
            check("train_down", {31'd0, lookup_taken}, {31'd0, untrain_exp[i]});
        end
        // counter is 00: one taken -> 01 (still 0), second -> 10
        drive(1'b1, 3'b000, 32'h5, 32'h5, 32'h100, 32'h400, 1'b0);
        step();
        check("sat_low_1", {31'd0, lookup_taken}, 32'd0);
        step();
        check("sat_low_2", {31'd0, lookup_taken}, 32'd1);
        // unconditional ops never train
        drive(1'b1, 3'b010, 32'h0, 32'h0, 32'h100, 32'h400, 1'b0);
        step(); step(); step();
        check("never_no_train", {31'd0, lookup_taken}, 32'd1);

        // 6. same-cycle lookup/update and aliasing: 'h200 shares entry with 'h100 (counter 10)
        drive(1'b1, 3'b001, 32'h7, 32'h7, 32'h200, 32'h500, 1'b0);
        #1;
        check("bypass_old", {31'd0, lookup_taken}, 32'd1);
        step();
        $display("alias update via 'h200 lookup('h100)=%0d", lookup_taken);
        check("alias_new", {31'd0, lookup_taken}, 32'd0);

        // 3. mispredicts
        drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h80, 32'h200, 1'b0);
        step();
        $display("misp1 misp=%0d redirect=%h", res_mispredict, res_redirect_pc);
        check("misp1_flag", {31'd0, res_mispredict}, 32'd1);
        check("misp1_redirect", res_redirect_pc, 32'h200);
        check("misp1_pc", res_pc, 32'h80);
        drive(1'b1, 3'b001, 32'h3, 32'h3, 32'h80, 32'h200, 1'b1);
        step();
        $display("misp2 misp=%0d redirect=%h", res_mispredict, res_redirect_pc);
        check("misp2_flag", {31'd0, res_mispredict}, 32'd1);
        check("misp2_redirect", res_redirect_pc, 32'h84);
        drive(1'b1, 3'b001, 32'h3, 32'h3, 32'h80, 32'h200, 1'b0);
        step();
        check("correct_pred", {31'd0, res_mispredict}, 32'd0);
        drive(1'b1, 3'b000, 32'h1, 32'h2, 32'hFFFF_FFFC, 32'h200, 1'b0);
        step();
        check("wrap_redirect", res_redirect_pc, 32'h0);
        drive(1'b0, 3'b011, 32'h0, 32'h0, 32'h90, 32'h600, 1'b0);
        step();
        check("novalid_valid", {31'd0, res_valid}, 32'd0);
        check("novalid_misp", {31'd0, res_mispredict}, 32'd0);
        check("novalid_redirect", res_redirect_pc, 32'h600);

        // 4. stall / flush; entry 0 counter is 01
        drive(1'b1, 3'b001, 32'h1, 32'h2, 32'h80, 32'h200, 1'b0);
        step();
        stall = 1'b1;
        drive(1'b1, 3'b000, 32'h9, 32'h9, 32'h100, 32'h700, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step();
            $display("stall cycle %0d valid=%0d pc=%h", i, res_valid, res_pc);
            check("stall_valid", {31'd0, res_valid}, 32'd1);
            check("stall_misp", {31'd0, res_mispredict}, 32'd1);
            check("stall_pc", res_pc, 32'h80);
            check("stall_bht", {31'd0, lookup_taken}, 32'd0);
        end
        flush = 1'b1;
        step();
        $display("flush valid=%0d misp=%0d", res_valid, res_mispredict);
        check("flush_valid", {31'd0, res_valid}, 32'd0);
        check("flush_misp", {31'd0, res_mispredict}, 32'd0);
        check("flush_pc_hold", res_pc, 32'h80);
        check("flush_redirect_hold", res_redirect_pc, 32'h200);
        check("flush_bht", {31'd0, lookup_taken}, 32'd0);
        stall = 1'b0;
        step();
        check("flush_nostall_bht", {31'd0, lookup_taken}, 32'd0);
        flush = 1'b0;

        // 5. train 'h100 to 11, then reset with a capture and training pending
        drive(1'b1, 3'b000, 32'h9, 32'h9, 32'h100, 32'h700, 1'b1);
        step(); step();
        check("pre_reset_lookup", {31'd0, lookup_taken}, 32'd1);
        check("pre_reset_valid", {31'd0, res_valid}, 32'd1);
        reset = 1'b1;
        step();
        $display("mid reset valid=%0d lookup=%0d", res_valid, lookup_taken);
        check("midrst_valid", {31'd0, res_valid}, 32'd0);
        check("midrst_lookup", {31'd0, lookup_taken}, 32'd0);
        check("midrst_pc", res_pc, 32'd0);
        reset = 1'b0;
        drive(1'b1, 3'b000, 32'h9, 32'h8, 32'h100, 32'h700, 1'b0);
        step();
        check("post_reset_down", {31'd0, lookup_taken}, 32'd0);
        drive(1'b1, 3'b000, 32'h9, 32'h9, 32'h100, 32'h700, 1'b0);
        step();
        check("post_reset_up", {31'd0, lookup_taken}, 32'd0);
        step();
        check("post_reset_up2", {31'd0, lookup_taken}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
